// File: rtl/ws2812b_frame_ctrl.sv
// rtl/ws2812b_frame_ctrl.sv - WS2812B frame scheduler feeding the serializer from a framebuffer
//
// Purpose:
//   On a start request or a periodic refresh tick, reads NUM_LEDS pixels in
//   order from a synchronous framebuffer RAM, reorders each {R,G,B} pixel to
//   {G,R,B}, bit-reverses it into the serializer's LSB-first word and hands
//   it over the bitstream_available/bitstream_read handshake.
//
// Optional feature (macro WS2812B_BRIGHTNESS_EN):
//   Adds input brightness[7:0]; each channel becomes (c*(brightness+1))>>8
//   in an extra SCALE state (3-cycle pixel gap instead of 2).
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   start                one-cycle request to send one frame
//   auto_en              enable periodic refresh every FRAME_CYCLES
//   fb_rd_en, fb_addr    framebuffer read strobe / address
//   fb_rdata             pixel {R,G,B}, valid one cycle after fb_rd_en
//   bitstream_available  word valid to serializer
//   bitstream            serializer word, bit 0 transmitted first
//   bitstream_read       serializer consumed the word
//   busy                 frame in progress
//   frame_done           one-cycle pulse after the last word is consumed
//   brightness           (WS2812B_BRIGHTNESS_EN only) global scale factor

module ws2812b_frame_ctrl #(
  parameter int NUM_LEDS     = 64,
  parameter int ADDR_W       = 6,
  parameter int FRAME_CYCLES = 180000,
  parameter int TIMER_W      = 18
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              auto_en,
`ifdef WS2812B_BRIGHTNESS_EN
  input  logic [7:0]        brightness,
`endif
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [23:0]       fb_rdata,
  output logic              bitstream_available,
  output logic [23:0]       bitstream,
  input  logic              bitstream_read,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FRAME_CYCLES - 1);
  localparam logic [ADDR_W-1:0]  INDEX_LAST = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
`ifdef WS2812B_BRIGHTNESS_EN
    S_SCALE   = 3'd5,
`endif
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic                pending_q, pending_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [23:0]         word_q, word_d;
`ifdef WS2812B_BRIGHTNESS_EN
  logic [23:0]         pixel_q, pixel_d;
`endif
  logic                tick;
  logic                trigger;

  // {R,G,B} -> serializer word: P = {G,R,B}, word[23-k] = P[k].
  function automatic logic [23:0] format_word(input logic [23:0] rgb);
    logic [23:0] p;
    logic [23:0] w;
    p = {rgb[15:8], rgb[23:16], rgb[7:0]};
    for (int k = 0; k < 24; k++) begin
      w[23-k] = p[k];
    end
    return w;
  endfunction

`ifdef WS2812B_BRIGHTNESS_EN
  // (c * (b+1)) >> 8; product never exceeds 255*256, so bits [15:8] suffice.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, c} * ({9'd0, b} + 17'd1);
    return prod[15:8];
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      pending_q <= 1'b0;
      timer_q   <= '0;
      word_q    <= '0;
`ifdef WS2812B_BRIGHTNESS_EN
      pixel_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      word_q    <= word_d;
`ifdef WS2812B_BRIGHTNESS_EN
      pixel_q   <= pixel_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    pending_d = pending_q;
    word_d    = word_q;
`ifdef WS2812B_BRIGHTNESS_EN
    pixel_d   = pixel_q;
`endif

    // Refresh timer: free-runs 0..FRAME_CYCLES-1 while enabled, parked at 0 otherwise.
    tick = auto_en && (timer_q == TIMER_LAST);
    if (!auto_en || tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    trigger = start | tick;
    // Any trigger outside IDLE (including the DONE cycle) is remembered once.
    if (trigger && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (trigger || pending_q) begin
          state_d   = S_FETCH;
          index_d   = '0;
          pending_d = 1'b0;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
`ifdef WS2812B_BRIGHTNESS_EN
        pixel_d = fb_rdata;
        state_d = S_SCALE;
`else
        word_d  = format_word(fb_rdata);
        state_d = S_PRESENT;
`endif
      end
`ifdef WS2812B_BRIGHTNESS_EN
      S_SCALE: begin
        word_d  = format_word({scale_chan(pixel_q[23:16], brightness),
                               scale_chan(pixel_q[15:8],  brightness),
                               scale_chan(pixel_q[7:0],   brightness)});
        state_d = S_PRESENT;
      end
`endif
      S_PRESENT: begin
        if (bitstream_read) begin
          if (index_q == INDEX_LAST) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state, so they are glitch-free
  // and drop together with the state on reset.
  assign fb_rd_en            = (state_q == S_FETCH);
  assign fb_addr             = index_q;
  assign bitstream_available = (state_q == S_PRESENT);
  assign bitstream           = word_q;
  assign busy                = (state_q != S_IDLE);
  assign frame_done          = (state_q == S_DONE);

endmodule

// File: tb/tb_ws2812b_frame_ctrl.sv
// tb/tb_ws2812b_frame_ctrl.sv - directed self-checking bench for ws2812b_frame_ctrl

module tb_ws2812b_frame_ctrl;

  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic        fb_rd_en;
  logic [2:0]  fb_addr;
  logic [23:0] fb_rdata = 24'd0;
  logic        bitstream_available;
  logic [23:0] bitstream;
  logic        bitstream_read = 1'b0;
  logic        busy;
  logic        frame_done;
`ifdef WS2812B_BRIGHTNESS_EN
  logic [7:0]  brightness = 8'd255;
`endif

  ws2812b_frame_ctrl #(
    .NUM_LEDS(NL), .ADDR_W(3), .FRAME_CYCLES(1000), .TIMER_W(10)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .auto_en(auto_en),
`ifdef WS2812B_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
    .bitstream_available(bitstream_available), .bitstream(bitstream),
    .bitstream_read(bitstream_read), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [0:NL-1];
  logic [23:0] exp_w [0:NL-1];
  always @(posedge clk) if (fb_rd_en) fb_rdata <= mem[fb_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ser_delay = 0;
  int ser_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rd_cnt = 0;
  logic [23:0] words[$];
  int starts[$];

  always @(posedge clk) cyc++;

  // Serializer model: consumes a word ser_delay cycles after seeing it.
  always @(posedge clk) begin
    #1;
    if (!resetn) begin
      bitstream_read = 1'b0;
      ser_cnt = 0;
    end else if (bitstream_read) begin
      bitstream_read = 1'b0;
    end else if (bitstream_available) begin
      if (ser_cnt >= ser_delay) begin
        bitstream_read = 1'b1;
        ser_cnt = 0;
      end else begin
        ser_cnt++;
      end
    end else begin
      ser_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (bitstream_available && bitstream_read) words.push_back(bitstream);
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (fb_rd_en) begin
      rd_cnt++;
      if (fb_addr == 3'd0) starts.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (done_cnt >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) step();
    checks++; if (fb_rd_en !== 1'b0) begin errors++; $display("FAIL reset_fb_rd_en got %b want 0", fb_rd_en); end
    checks++; if (fb_addr !== 3'd0) begin errors++; $display("FAIL reset_fb_addr got %h want 0", fb_addr); end
    checks++; if (bitstream_available !== 1'b0) begin errors++; $display("FAIL reset_available got %b want 0", bitstream_available); end
    checks++; if (bitstream !== 24'd0) begin errors++; $display("FAIL reset_bitstream got %h want 0", bitstream); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_frame();
    bit ok;
    int base;
    ser_delay = 0;
    words.delete();
    base = done_cnt;
    pulse_start();
    wait_done(base + 1, 200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL frame_timeout got %b want 1", ok); end
    checks++; if (words.size() !== NL) begin errors++; $display("FAIL frame_word_count got %0d want %0d", words.size(), NL); end
    for (int i = 0; i < NL; i++) begin
      if (i < words.size()) begin
        checks++; if (words[i] !== exp_w[i]) begin errors++; $display("FAIL frame_word%0d got %h want %h", i, words[i], exp_w[i]); end
      end
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after_done got %b want 0", busy); end
    repeat (5) step();
    checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL frame_done_once got %0d want %0d", done_cnt, base + 1); end
  endtask

  task automatic test_stall();
    bit ok;
    bit stable;
    int base;
    int r0;
    logic [23:0] w;
    ser_delay = 100;
    base = done_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bitstream_available) begin ok = 1'b1; break; end
      step();
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_available_timeout got %b want 1", ok); end
    w = bitstream;
    r0 = rd_cnt;
    stable = 1'b1;
    repeat (100) begin
      step();
      if (bitstream_available !== 1'b1 || bitstream !== w || rd_cnt != r0) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stall_hold got %b want 1", stable); end
    checks++; if (w !== 24'h80FF00) begin errors++; $display("FAIL stall_word got %h want 80ff00", w); end
    wait_done(base + 1, 1000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_done_timeout got %b want 1", ok); end
    ser_delay = 0;
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    int d1;
    ser_delay = 0;
    base = done_cnt;
    starts.delete();
    pulse_start();
    repeat (3) step();
    pulse_start();
    step();
    pulse_start();
    wait_done(base + 1, 200, ok);
    d1 = done_cyc;
    wait_done(base + 2, 200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_second_frame got %b want 1", ok); end
    checks++; if (starts.size() !== 2) begin errors++; $display("FAIL b2b_start_count got %0d want 2", starts.size()); end
    // DONE at cycle d1, IDLE serves pending at d1+1, FETCH of pixel 0 at d1+2.
    if (starts.size() >= 2) begin
      checks++; if (starts[1] !== d1 + 2) begin errors++; $display("FAIL b2b_restart_cycle got %0d want %0d", starts[1], d1 + 2); end
    end
    repeat (100) step();
    checks++; if (done_cnt !== base + 2) begin errors++; $display("FAIL b2b_no_extra got %0d want %0d", done_cnt, base + 2); end
  endtask

  task automatic test_auto();
    int n;
    int diff;
    starts.delete();
    auto_en = 1'b1;
    repeat (2600) step();
    checks++; if (starts.size() !== 2) begin errors++; $display("FAIL auto_frame_count got %0d want 2", starts.size()); end
    diff = (starts.size() >= 2) ? (starts[1] - starts[0]) : -1;
    checks++; if (diff !== 1000) begin errors++; $display("FAIL auto_period got %0d want 1000", diff); end
    auto_en = 1'b0;
    n = starts.size();
    repeat (2100) step();
    checks++; if (starts.size() !== n) begin errors++; $display("FAIL auto_disable got %0d want %0d", starts.size(), n); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    ser_delay = 50;
    words.delete();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (words.size() == 2 && bitstream_available) begin ok = 1'b1; break; end
      step();
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midreset_reach_pixel2 got %b want 1", ok); end
    resetn = 1'b0;
    step();
    checks++; if (bitstream_available !== 1'b0) begin errors++; $display("FAIL midreset_available got %b want 0", bitstream_available); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (bitstream !== 24'd0) begin errors++; $display("FAIL midreset_bitstream got %h want 0", bitstream); end
    resetn = 1'b1;
    ser_delay = 0;
    step();
    words.delete();
    base = done_cnt;
    pulse_start();
    wait_done(base + 1, 200, ok);
    checks++; if (words.size() !== NL) begin errors++; $display("FAIL midreset_word_count got %0d want %0d", words.size(), NL); end
    if (words.size() > 0) begin
      checks++; if (words[0] !== 24'h80FF00) begin errors++; $display("FAIL midreset_first_word got %h want 80ff00", words[0]); end
    end
  endtask

`ifdef WS2812B_BRIGHTNESS_EN
  task automatic test_brightness();
    bit ok;
    int base;
    logic [23:0] saved;
    saved = mem[0];
    mem[0] = 24'hFF8002;
    brightness = 8'd127;
    words.delete();
    base = done_cnt;
    pulse_start();
    wait_done(base + 1, 200, ok);
    // R=127, G=64, B=1 -> {G,R,B}=407F01, bit-reversed.
    if (words.size() > 0) begin
      checks++; if (words[0] !== 24'h80FE02) begin errors++; $display("FAIL bright_word got %h want 80fe02", words[0]); end
    end else begin
      checks++; errors++; $display("FAIL bright_no_word got 0 want 1");
    end
    brightness = 8'd255;
    mem[0] = saved;
  endtask
`endif

  initial begin
    // {R,G,B} pixels and their hand-computed serializer words.
    mem[0] = 24'hFF0001; exp_w[0] = 24'h80FF00;
    mem[1] = 24'h123456; exp_w[1] = 24'h6A482C;
    mem[2] = 24'h00FF00; exp_w[2] = 24'h0000FF;
    mem[3] = 24'h0000FF; exp_w[3] = 24'hFF0000;
    test_reset();
    test_frame();
    test_stall();
    test_back_to_back();
    test_auto();
    test_reset_mid();
`ifdef WS2812B_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
